// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch-side push channel, decode-side head channel with
// pre-split RV64I fields, and the branch flush.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_instr;
  logic [6:0]    out_opcode;
  logic [4:0]    out_rd;
  logic [2:0]    out_funct3;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [CW-1:0] count;

  // Queue side.
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rd, out_funct3, out_rs1, out_rs2, count
  );

  // Fetch/decode side.
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rd, out_funct3, out_rs1, out_rs2, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode: circular buffer of {pc, instr}
// with valid/ready on both sides, branch flush, and pre-split decode fields.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic push, pop;

  assign q.in_ready  = (count != CW'(DEPTH));
  assign q.out_valid = (count != '0);
  assign push = q.in_valid  & q.in_ready  & ~q.flush;
  assign pop  = q.out_valid & q.out_ready & ~q.flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; out_valid masks stale words, and leaving the array
  // unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr]    <= q.in_pc;
      instr_mem[wr_ptr] <= q.in_instr;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    q.out_pc    = '0;
    q.out_instr = NOP;
    if (q.out_valid) begin
      q.out_pc    = pc_mem[rd_ptr];
      q.out_instr = instr_mem[rd_ptr];
    end
  end

  assign q.out_opcode = q.out_instr[6:0];
  assign q.out_rd     = q.out_instr[11:7];
  assign q.out_funct3 = q.out_instr[14:12];
  assign q.out_rs1    = q.out_instr[19:15];
  assign q.out_rs2    = q.out_instr[24:20];
  assign q.count      = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, streaming, full+pop, flush,
// and reset mid-operation, with hand-computed expectations.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_pc !== 64'd0 || bus.out_instr !== 32'h00000013 ||
        bus.out_opcode !== 7'h13 || bus.out_rd !== 5'd0 || bus.out_funct3 !== 3'd0 ||
        bus.out_rs1 !== 5'd0 || bus.out_rs2 !== 5'd0) begin
      n_fail++;
      $display("FAIL %s: count=%0d out_valid=%b in_ready=%b out_pc=%h out_instr=%h op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d, required reset values",
               tag, bus.count, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr,
               bus.out_opcode, bus.out_rd, bus.out_funct3, bus.out_rs1, bus.out_rs2);
    end
  endtask

  task automatic push_n(input logic [63:0] base, input int n);
    bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = base + 64'(4 * i);
      bus.in_instr = 32'h00000013;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'd0;
    bus.in_instr = 32'h00500093;
    for (int i = 0; i < 4; i++) begin
      step();
      check_reset_values($sformatf("reset_hold_%0d", i));
    end
    reset = 1'b0;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd0 || bus.out_rd !== 5'd1 ||
        bus.out_opcode !== 7'h13 || bus.out_rs1 !== 5'd0 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL first_push: valid=%b pc=%h rd=%0d op=%h rs1=%0d count=%0d, required 1 0 1 13 0 1",
               bus.out_valid, bus.out_pc, bus.out_rd, bus.out_opcode, bus.out_rs1, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pop: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] instrs [4];
    instrs[0] = 32'h00100093;
    instrs[1] = 32'h00200113;
    instrs[2] = 32'h002081b3;
    instrs[3] = 32'h40208233;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 64'(4 * i);
      bus.in_instr = instrs[i];
      step();
    end
    n_checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d in_ready=%b, required 4 0", bus.count, bus.in_ready);
    end
    bus.in_pc    = 64'd16;
    bus.in_instr = 32'h00000013;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.count !== 3'd4 || bus.out_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL fill_reject: count=%0d out_pc=%h, required 4 0", bus.count, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i) || bus.out_instr !== instrs[i]) begin
        n_fail++;
        $display("FAIL drain_%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, 64'(4 * i), instrs[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2 || bus.out_rd !== 5'd3) begin
          n_fail++;
          $display("FAIL drain_fields: rs1=%0d rs2=%0d rd=%0d, required 1 2 3",
                   bus.out_rs1, bus.out_rs2, bus.out_rd);
        end
      end
      step();
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      bus.in_pc    = 64'(4 * k);
      bus.in_instr = 32'h00000013 | (32'(k & 31) << 7);
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * k) || bus.count !== 3'd1 ||
          bus.out_rd !== 5'(k & 31)) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%h count=%0d rd=%0d, required 1 %h 1 %0d",
                 k, bus.out_valid, bus.out_pc, bus.count, bus.out_rd, 64'(4 * k), k & 31);
      end
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_end: count=%0d, required 0", bus.count);
    end
  endtask

  task automatic test_full_pop();
    logic [63:0] order [4];
    push_n(64'h40, 4);
    n_checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_full: count=%0d in_ready=%b, required 4 0", bus.count, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h50;
    bus.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_pc !== 64'h44) begin
      n_fail++;
      $display("FAIL fullpop_after: count=%0d in_ready=%b out_pc=%h, required 3 1 44",
               bus.count, bus.in_ready, bus.out_pc);
    end
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_retry: count=%0d, required 4", bus.count);
    end
    order[0] = 64'h44; order[1] = 64'h48; order[2] = 64'h4c; order[3] = 64'h50;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_pc !== order[i]) begin
        n_fail++;
        $display("FAIL fullpop_order_%0d: out_pc=%h, required %h", i, bus.out_pc, order[i]);
      end
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_n(64'h10, 3);
    n_checks++;
    if (bus.count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_pre: count=%0d, required 3", bus.count);
    end
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h100;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_pc     = 64'h200;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_instr !== 32'h00000013) begin
      n_fail++;
      $display("FAIL flush_after: count=%0d valid=%b in_ready=%b instr=%h, required 0 0 1 00000013",
               bus.count, bus.out_valid, bus.in_ready, bus.out_instr);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.count !== 3'd1 || bus.out_pc !== 64'h200) begin
      n_fail++;
      $display("FAIL flush_push: count=%0d out_pc=%h, required 1 200", bus.count, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stale: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    push_n(64'h300, 2);
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h308;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    check_reset_values("reset_mid");
    step();
    check_reset_values("reset_mid_settled");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
